// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder, active-low digit
// enables, a blank guard cycle between digits and a tear-free value load.
module display_scan_ctrl #(
    parameter int NUM_DIG     = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   habilitar,
    input  logic                   apaga_zeros,
    input  logic [4*NUM_DIG-1:0]   valor_in,
    input  logic                   carregar,
    output logic                   aceito,
    output logic [3:0]             bcd_sel,
    output logic [NUM_DIG-1:0]     anodos,
    output logic                   fim_quadro
);

    localparam int                   IDX_W    = $clog2(NUM_DIG);
    localparam logic [DIV_WIDTH-1:0] TICK_AT  = DIV_WIDTH'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DIG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        SCAN  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [DIV_WIDTH-1:0]   presc, presc_nxt;
    logic [4*NUM_DIG-1:0]   active, active_nxt;
    logic [4*NUM_DIG-1:0]   pending, pending_nxt;
    logic                   pend_full, pend_full_nxt;
    logic [NUM_DIG-1:0]     anodos_nxt;
    logic [3:0]             bcd_nxt;
    logic                   aceito_nxt;
    logic                   fim_nxt;
    logic                   transfer;

    // Code sent to the decoder for digit k; leading zeros above digit 0 become blank.
    function automatic logic [3:0] shown(input logic [4*NUM_DIG-1:0] val,
                                         input logic [IDX_W-1:0]     k,
                                         input logic                 blank_lz);
        logic       upper_zero;
        logic [3:0] code;
        upper_zero = 1'b1;
        code       = 4'h0;
        for (int j = 0; j < NUM_DIG; j++) begin
            if (j >= int'(k) && val[4*j +: 4] != 4'h0)
                upper_zero = 1'b0;
            if (j == int'(k))
                code = val[4*j +: 4];
        end
        if (blank_lz && k != '0 && upper_zero)
            return 4'hF;
        return code;
    endfunction

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        presc_nxt     = presc;
        active_nxt    = active;
        pending_nxt   = pending;
        pend_full_nxt = pend_full;
        anodos_nxt    = anodos;
        bcd_nxt       = bcd_sel;
        aceito_nxt    = 1'b0;
        fim_nxt       = 1'b0;
        transfer      = 1'b0;

        if (!habilitar) begin
            state_nxt  = IDLE;
            idx_nxt    = '0;
            presc_nxt  = '0;
            anodos_nxt = '1;
            bcd_nxt    = 4'hF;
            transfer   = (state == IDLE) && pend_full;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = GUARD;
                    anodos_nxt = '1;
                    bcd_nxt    = 4'hF;
                    transfer   = pend_full;
                end
                GUARD: begin
                    state_nxt  = SCAN;
                    anodos_nxt = ~(NUM_DIG'(1) << idx);
                    bcd_nxt    = shown(active, idx, apaga_zeros);
                end
                SCAN: begin
                    if (presc == TICK_AT) begin
                        state_nxt  = GUARD;
                        presc_nxt  = '0;
                        anodos_nxt = '1;
                        bcd_nxt    = 4'hF;
                        if (idx == LAST_IDX) begin
                            idx_nxt  = '0;
                            fim_nxt  = 1'b1;
                            transfer = pend_full;
                        end else begin
                            idx_nxt  = idx + IDX_W'(1);
                        end
                    end else begin
                        presc_nxt = presc + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    anodos_nxt = '1;
                    bcd_nxt    = 4'hF;
                end
            endcase
        end

        // A transfer always beats a capture; the requester keeps carregar high meanwhile.
        if (transfer) begin
            active_nxt    = pending;
            pend_full_nxt = 1'b0;
        end else if (carregar && !pend_full) begin
            pending_nxt   = valor_in;
            pend_full_nxt = 1'b1;
            aceito_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            presc      <= '0;
            active     <= '0;
            pending    <= '0;
            pend_full  <= 1'b0;
            anodos     <= '1;
            bcd_sel    <= 4'hF;
            aceito     <= 1'b0;
            fim_quadro <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            presc      <= presc_nxt;
            active     <= active_nxt;
            pending    <= pending_nxt;
            pend_full  <= pend_full_nxt;
            anodos     <= anodos_nxt;
            bcd_sel    <= bcd_nxt;
            aceito     <= aceito_nxt;
            fim_quadro <= fim_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIG=4, REFRESH_DIV=3
// (digit period 4 cycles, frame period 16 cycles).
module tb_display_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        habilitar;
    logic        apaga_zeros;
    logic [15:0] valor_in;
    logic        carregar;
    logic        aceito;
    logic [3:0]  bcd_sel;
    logic [3:0]  anodos;
    logic        fim_quadro;

    int checks   = 0;
    int failures = 0;

    display_scan_ctrl #(
        .NUM_DIG    (ND),
        .DIV_WIDTH  (8),
        .REFRESH_DIV(RD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .habilitar  (habilitar),
        .apaga_zeros(apaga_zeros),
        .valor_in   (valor_in),
        .carregar   (carregar),
        .aceito     (aceito),
        .bcd_sel    (bcd_sel),
        .anodos     (anodos),
        .fim_quadro (fim_quadro)
    );

    always #5 clk = ~clk;

    // Cycle c counts negedges after habilitar rises from IDLE: c=1 is the first
    // guard, then each digit is lit 3 cycles followed by one blank guard cycle.
    function automatic int lit_digit(input int c);
        int p;
        if (c < 2) return -1;
        p = (c - 2) % 16;
        if (p % 4 == 3) return -1;
        return p / 4;
    endfunction

    function automatic logic exp_fim(input int c);
        return (c >= 2) && ((c - 2) % 16 == 15);
    endfunction

    function automatic logic [3:0] an_of(input int d);
        if (d < 0) return 4'hF;
        return 4'hF ^ (4'h1 << d);
    endfunction

    // Drop habilitar for one cycle, then raise it; returns at cycle 0.
    task automatic restart;
        @(negedge clk);
        habilitar = 1'b0;
        @(negedge clk);
        habilitar = 1'b1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b1;
        habilitar   = 1'b0;
        apaga_zeros = 1'b0;
        carregar    = 1'b0;
        valor_in    = 16'h0000;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (anodos !== 4'hF) begin failures++; $display("FAIL reset_anodos got=%b exp=1111", anodos); end
        checks++; if (bcd_sel !== 4'hF) begin failures++; $display("FAIL reset_bcd got=%h exp=f", bcd_sel); end
        checks++; if (aceito !== 1'b0) begin failures++; $display("FAIL reset_aceito got=%b exp=0", aceito); end
        checks++; if (fim_quadro !== 1'b0) begin failures++; $display("FAIL reset_fim got=%b exp=0", fim_quadro); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (anodos !== 4'hF) begin failures++; $display("FAIL idle_anodos got=%b exp=1111", anodos); end
    endtask

    task automatic test_scan;
        logic [3:0] tab [0:3];
        int d;
        logic [3:0] ea, eb;
        tab = '{4'h4, 4'h3, 4'h2, 4'h1};
        // Load in IDLE: capture, then transfer on the following cycle.
        carregar = 1'b1;
        valor_in = 16'h1234;
        @(negedge clk);
        checks++; if (aceito !== 1'b1) begin failures++; $display("FAIL scan_load_aceito got=%b exp=1", aceito); end
        carregar = 1'b0;
        @(negedge clk);
        checks++; if (aceito !== 1'b0) begin failures++; $display("FAIL scan_load_aceito_off got=%b exp=0", aceito); end
        restart();
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            d  = lit_digit(c);
            ea = an_of(d);
            eb = (d < 0) ? 4'hF : tab[d];
            checks++; if (anodos !== ea) begin failures++; $display("FAIL scan_anodos c=%0d got=%b exp=%b", c, anodos, ea); end
            checks++; if (bcd_sel !== eb) begin failures++; $display("FAIL scan_bcd c=%0d got=%h exp=%h", c, bcd_sel, eb); end
            checks++; if (fim_quadro !== exp_fim(c)) begin failures++; $display("FAIL scan_fim c=%0d got=%b exp=%b", c, fim_quadro, exp_fim(c)); end
            checks++; if (aceito !== 1'b0) begin failures++; $display("FAIL scan_aceito c=%0d got=%b exp=0", c, aceito); end
        end
    endtask

    task automatic test_load_blank;
        logic [3:0] tab [0:1][0:3];
        int d;
        logic [3:0] ea, eb;
        logic eacc;
        tab[0] = '{4'h4, 4'h3, 4'h2, 4'h1};
        tab[1] = '{4'h7, 4'hF, 4'hF, 4'hF};
        apaga_zeros = 1'b1;
        restart();
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            d    = lit_digit(c);
            ea   = an_of(d);
            eb   = (d < 0) ? 4'hF : tab[(c - 2) / 16][d];
            eacc = (c == 4);
            checks++; if (anodos !== ea) begin failures++; $display("FAIL lz_anodos c=%0d got=%b exp=%b", c, anodos, ea); end
            checks++; if (bcd_sel !== eb) begin failures++; $display("FAIL lz_bcd c=%0d got=%h exp=%h", c, bcd_sel, eb); end
            checks++; if (fim_quadro !== exp_fim(c)) begin failures++; $display("FAIL lz_fim c=%0d got=%b exp=%b", c, fim_quadro, exp_fim(c)); end
            checks++; if (aceito !== eacc) begin failures++; $display("FAIL lz_aceito c=%0d got=%b exp=%b", c, aceito, eacc); end
            if (c == 3) begin
                carregar = 1'b1;
                valor_in = 16'h0007;
            end
            if (c == 4) carregar = 1'b0;
        end
    endtask

    task automatic test_zero;
        logic [3:0] tab [0:1][0:3];
        int d;
        logic [3:0] ea, eb;
        tab[0] = '{4'h0, 4'hF, 4'hF, 4'hF};
        tab[1] = '{4'h0, 4'h0, 4'h0, 4'h0};
        @(negedge clk);
        habilitar = 1'b0;
        @(negedge clk);
        carregar = 1'b1;
        valor_in = 16'h0000;
        @(negedge clk);
        checks++; if (aceito !== 1'b1) begin failures++; $display("FAIL zero_load_aceito got=%b exp=1", aceito); end
        carregar = 1'b0;
        @(negedge clk);
        apaga_zeros = 1'b1;
        habilitar   = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            d  = lit_digit(c);
            ea = an_of(d);
            eb = (d < 0) ? 4'hF : tab[(c - 2) / 16][d];
            checks++; if (anodos !== ea) begin failures++; $display("FAIL zero_anodos c=%0d got=%b exp=%b", c, anodos, ea); end
            checks++; if (bcd_sel !== eb) begin failures++; $display("FAIL zero_bcd c=%0d got=%h exp=%h", c, bcd_sel, eb); end
            checks++; if (fim_quadro !== exp_fim(c)) begin failures++; $display("FAIL zero_fim c=%0d got=%b exp=%b", c, fim_quadro, exp_fim(c)); end
            if (c == 17) apaga_zeros = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] tab [0:2][0:3];
        int d;
        logic [3:0] ea, eb;
        logic eacc;
        tab[0] = '{4'h0, 4'h0, 4'h0, 4'h0};
        tab[1] = '{4'h8, 4'h7, 4'h6, 4'h5};
        tab[2] = '{4'hC, 4'hB, 4'hA, 4'h9};
        restart();
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            d    = lit_digit(c);
            ea   = an_of(d);
            eb   = (d < 0) ? 4'hF : tab[(c - 2) / 16][d];
            eacc = (c == 4) || (c == 18);
            checks++; if (anodos !== ea) begin failures++; $display("FAIL b2b_anodos c=%0d got=%b exp=%b", c, anodos, ea); end
            checks++; if (bcd_sel !== eb) begin failures++; $display("FAIL b2b_bcd c=%0d got=%h exp=%h", c, bcd_sel, eb); end
            checks++; if (fim_quadro !== exp_fim(c)) begin failures++; $display("FAIL b2b_fim c=%0d got=%b exp=%b", c, fim_quadro, exp_fim(c)); end
            checks++; if (aceito !== eacc) begin failures++; $display("FAIL b2b_aceito c=%0d got=%b exp=%b", c, aceito, eacc); end
            if (c == 3) begin
                carregar = 1'b1;
                valor_in = 16'h5678;
            end
            if (c == 4)  valor_in = 16'h9ABC;
            if (c == 18) carregar = 1'b0;
        end
    endtask

    task automatic test_hab_drop;
        logic [3:0] tab [0:3];
        int d;
        logic [3:0] ea, eb;
        tab = '{4'hC, 4'hB, 4'hA, 4'h9};
        restart();
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            d  = lit_digit(c);
            ea = an_of(d);
            eb = (d < 0) ? 4'hF : tab[d];
            checks++; if (anodos !== ea) begin failures++; $display("FAIL hab_anodos c=%0d got=%b exp=%b", c, anodos, ea); end
            checks++; if (bcd_sel !== eb) begin failures++; $display("FAIL hab_bcd c=%0d got=%h exp=%h", c, bcd_sel, eb); end
        end
        habilitar = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (anodos !== 4'hF) begin failures++; $display("FAIL hab_off_anodos k=%0d got=%b exp=1111", k, anodos); end
            checks++; if (bcd_sel !== 4'hF) begin failures++; $display("FAIL hab_off_bcd k=%0d got=%h exp=f", k, bcd_sel); end
        end
        habilitar = 1'b1;
        @(negedge clk);
        checks++; if (anodos !== 4'hF) begin failures++; $display("FAIL hab_guard_anodos got=%b exp=1111", anodos); end
        checks++; if (bcd_sel !== 4'hF) begin failures++; $display("FAIL hab_guard_bcd got=%h exp=f", bcd_sel); end
        @(negedge clk);
        checks++; if (anodos !== 4'b1110) begin failures++; $display("FAIL hab_relit_anodos got=%b exp=1110", anodos); end
        checks++; if (bcd_sel !== 4'hC) begin failures++; $display("FAIL hab_relit_bcd got=%h exp=c", bcd_sel); end
    endtask

    task automatic test_async_reset;
        logic [3:0] tab [0:3];
        int d;
        logic [3:0] ea, eb;
        logic eacc;
        tab = '{4'hC, 4'hB, 4'hA, 4'h9};
        restart();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            d    = lit_digit(c);
            ea   = an_of(d);
            eb   = (d < 0) ? 4'hF : tab[d];
            eacc = (c == 4);
            checks++; if (anodos !== ea) begin failures++; $display("FAIL ar_pre_anodos c=%0d got=%b exp=%b", c, anodos, ea); end
            checks++; if (bcd_sel !== eb) begin failures++; $display("FAIL ar_pre_bcd c=%0d got=%h exp=%h", c, bcd_sel, eb); end
            checks++; if (aceito !== eacc) begin failures++; $display("FAIL ar_pre_aceito c=%0d got=%b exp=%b", c, aceito, eacc); end
            if (c == 3) begin
                carregar = 1'b1;
                valor_in = 16'h4321;
            end
            if (c == 4) carregar = 1'b0;
        end
        // Reset lands mid-digit, well away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checks++; if (anodos !== 4'hF) begin failures++; $display("FAIL ar_now_anodos got=%b exp=1111", anodos); end
        checks++; if (bcd_sel !== 4'hF) begin failures++; $display("FAIL ar_now_bcd got=%h exp=f", bcd_sel); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            d  = lit_digit(c);
            ea = an_of(d);
            eb = (d < 0) ? 4'hF : 4'h0;
            checks++; if (anodos !== ea) begin failures++; $display("FAIL ar_post_anodos c=%0d got=%b exp=%b", c, anodos, ea); end
            checks++; if (bcd_sel !== eb) begin failures++; $display("FAIL ar_post_bcd c=%0d got=%h exp=%h", c, bcd_sel, eb); end
            checks++; if (aceito !== 1'b0) begin failures++; $display("FAIL ar_post_aceito c=%0d got=%b exp=0", c, aceito); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_blank();
        test_zero();
        test_back_to_back();
        test_hab_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
